ahb_uart_rx: RTL and testbench

AHB_UART_RX -- requirements
Module: ahb_uart_rx

---
 rtl/ahb_uart_rx_if.sv | 12 +
 rtl/ahb_uart_rx.sv | 134 +++++++++++++
 tb/tb_ahb_uart_rx.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_uart_rx_if.sv
// ahb_uart_rx_if: AHB-lite slave bus bundle for the UART receiver
interface ahb_uart_rx_if;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HWRITE;
  logic        HSEL;
  logic        HREADY;
  logic        HRESP;
  modport master (output HADDR, HWDATA, HWRITE, HSEL, input HRDATA, HREADY, HRESP);
  modport slave (input HADDR, HWDATA, HWRITE, HSEL, output HRDATA, HREADY, HRESP);
endinterface

// File: rtl/ahb_uart_rx.sv
// ahb_uart_rx: AHB-lite slave wrapping an 8N1 UART receiver with DATA/STAT/DVDR registers
module ahb_uart_rx #(
  parameter logic [31:0] DEFAULT_DIVIDER = 32'd434
) (
  input  logic         HCLK,
  input  logic         HRESET,
  ahb_uart_rx_if.slave bus,
  input  logic         UART_RX,
  output logic         RX_IRQ
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, div_q, div_d, dvdr_q, dvdr_d, div_new;
  logic [7:0]  shift_q, shift_d, rx_data_q, rx_data_d;
  logic [2:0]  bit_q, bit_d, sync_q, sync_d;
  logic [3:0]  addr_q, addr_d;
  logic        write_q, write_d, sel_q, sel_d;
  logic        rx_valid_q, rx_valid_d, rx_busy_q, rx_busy_d;
  logic        overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic        line, fall, expire, good, bad, rd_data, wr_stat, wr_dvdr, unused_haddr;

  assign line    = sync_q[1];
  assign fall    = sync_q[2] & ~sync_q[1];
  assign expire  = cnt_q == 32'd0;
  assign div_new = dvdr_q < 32'd2 ? 32'd2 : dvdr_q;
  assign rd_data = sel_q & ~write_q & (addr_q == 4'd0);
  assign wr_stat = sel_q & write_q & (addr_q == 4'd1);
  assign wr_dvdr = sel_q & write_q & (addr_q == 4'd2);
  assign bus.HREADY = 1'b1;
  assign bus.HRESP  = 1'b0;
  assign RX_IRQ     = rx_valid_q;
  assign unused_haddr = ^{bus.HADDR[31:6], bus.HADDR[1:0]};

  // state and register storage, all cleared by synchronous reset
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      dvdr_q      <= DEFAULT_DIVIDER;
      shift_q     <= '0;
      bit_q       <= '0;
      sync_q      <= '1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_busy_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      sel_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      dvdr_q      <= dvdr_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      sync_q      <= sync_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_busy_q   <= rx_busy_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      sel_q       <= sel_d;
    end
  end

  // receive FSM: mid-bit sampling driven by a down-counter reloaded from the latched divider
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    rx_busy_d = rx_busy_q;
    good      = 1'b0;
    bad       = 1'b0;
    case (state_q)
      IDLE: if (fall) begin
        div_d     = div_new;
        cnt_d     = (div_new >> 1) - 32'd1;
        rx_busy_d = 1'b1;
        state_d   = START;
      end
      START: if (!expire) cnt_d = cnt_q - 32'd1;
      else if (!line) begin
        cnt_d   = div_q - 32'd1;
        bit_d   = '0;
        state_d = DATA;
      end else begin
        rx_busy_d = 1'b0;
        state_d   = IDLE;
      end
      DATA: if (!expire) cnt_d = cnt_q - 32'd1;
      else begin
        shift_d = {line, shift_q[7:1]};
        cnt_d   = div_q - 32'd1;
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (!expire) cnt_d = cnt_q - 32'd1;
      else begin
        good      = line;
        bad       = ~line;
        rx_busy_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // bus phase capture, synchronizer and status flags; set events beat clears
  always_comb begin
    addr_d      = bus.HADDR[5:2];
    write_d     = bus.HWRITE;
    sel_d       = bus.HSEL;
    sync_d      = {sync_q[1:0], UART_RX};
    dvdr_d      = wr_dvdr ? bus.HWDATA : dvdr_q;
    rx_data_d   = good & (~rx_valid_q | rd_data) ? shift_q : rx_data_q;
    rx_valid_d  = good | (rx_valid_q & ~rd_data);
    overrun_d   = (good & rx_valid_q & ~rd_data) | (overrun_q & ~(wr_stat & bus.HWDATA[3]));
    frame_err_d = bad | (frame_err_q & ~(wr_stat & bus.HWDATA[2]));
  end

  // read mux; STAT status bits line up with their write-one-to-clear positions
  always_comb begin
    bus.HRDATA = addr_q == 4'd0 ? {24'b0, rx_data_q} :
                 addr_q == 4'd1 ? {16'h55AA, 12'b0, overrun_q, frame_err_q, rx_valid_q, rx_busy_q} :
                 addr_q == 4'd2 ? dvdr_q : 32'd0;
  end
endmodule

// File: tb/tb_ahb_uart_rx.sv
// tb_ahb_uart_rx: directed and randomized checks of the AHB UART receiver against a frame-level model
module tb_ahb_uart_rx;
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  logic UART_RX = 1'b1;
  logic RX_IRQ;
  int tests = 0;
  int fails = 0;
  logic [7:0] m_data = 8'h00;
  logic m_valid = 1'b0;
  logic m_ovr = 1'b0;
  logic m_ferr = 1'b0;

  ahb_uart_rx_if bus();

  ahb_uart_rx dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus), .UART_RX(UART_RX), .RX_IRQ(RX_IRQ));

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ahb_write(input logic [3:0] off, input logic [31:0] d);
    @(posedge HCLK); #1;
    bus.HADDR = {26'b0, off, 2'b0};
    bus.HSEL = 1'b1;
    bus.HWRITE = 1'b1;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0;
    bus.HWRITE = 1'b0;
    bus.HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [3:0] off, output logic [31:0] d);
    @(posedge HCLK); #1;
    bus.HADDR = {26'b0, off, 2'b0};
    bus.HSEL = 1'b1;
    bus.HWRITE = 1'b0;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0;
    d = bus.HRDATA;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
    @(posedge HCLK); #1 UART_RX = 1'b0;
    repeat (div) @(posedge HCLK);
    for (int i = 0; i < 8; i++) begin
      #1 UART_RX = b[i];
      repeat (div) @(posedge HCLK);
    end
    #1 UART_RX = stop;
    repeat (div) @(posedge HCLK);
    #1 UART_RX = 1'b1;
  endtask

  task automatic idle(input int n);
    UART_RX = 1'b1;
    repeat (n) @(posedge HCLK);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic ok);
    if (!ok) m_ferr = 1'b1;
    else if (m_valid) m_ovr = 1'b1;
    else begin
      m_data = b;
      m_valid = 1'b1;
    end
  endtask

  task automatic stat_chk(input string tag);
    logic [31:0] d;
    ahb_read(4'd1, d);
    check(tag, d, {16'h55AA, 12'b0, m_ovr, m_ferr, m_valid, 1'b0});
  endtask

  task automatic data_chk(input string tag);
    logic [31:0] d;
    ahb_read(4'd0, d);
    check(tag, d, {24'b0, m_data});
    m_valid = 1'b0;
  endtask

  task automatic stat_w1c(input logic [31:0] d);
    ahb_write(4'd1, d);
    if (d[3]) m_ovr = 1'b0;
    if (d[2]) m_ferr = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int cyc;
    int div;
    logic [7:0] b;
    logic ok;
    bus.HADDR = '0;
    bus.HWDATA = '0;
    bus.HWRITE = 1'b0;
    bus.HSEL = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    check("rst_irq", {31'b0, RX_IRQ}, 32'd0);
    check("rst_hready", {31'b0, bus.HREADY}, 32'd1);
    check("rst_hresp", {31'b0, bus.HRESP}, 32'd0);
    ahb_read(4'd1, d); check("rst_stat", d, 32'h55AA0000);
    ahb_read(4'd2, d); check("rst_dvdr", d, 32'd434);
    ahb_read(4'd0, d); check("rst_data", d, 32'd0);
    ahb_read(4'd5, d); check("unmapped_rd", d, 32'd0);

    ahb_write(4'd2, 32'd16);
    ahb_read(4'd2, d); check("dvdr_wr", d, 32'd16);
    fork
      send_frame(8'hA5, 1'b1, 16);
      begin
        cyc = 0;
        @(posedge HCLK);
        while (!RX_IRQ && cyc < 200) begin
          @(posedge HCLK); #2;
          cyc++;
        end
      end
    join
    model_frame(8'hA5, 1'b1);
    check("a5_irq", {31'b0, RX_IRQ}, 32'd1);
    check("a5_latency", {31'b0, cyc <= 164}, 32'd1);
    idle(16);
    ahb_read(4'd0, d); check("a5_data", d, 32'h000000A5);
    m_valid = 1'b0;
    @(posedge HCLK); #1;
    check("a5_irq_clr", {31'b0, RX_IRQ}, 32'd0);

    @(posedge HCLK); #1 UART_RX = 1'b0;
    repeat (5) @(posedge HCLK);
    #1 UART_RX = 1'b1;
    ahb_read(4'd1, d); check("glitch_busy", d, 32'h55AA0001);
    idle(30);
    ahb_read(4'd1, d); check("glitch_stat", d, 32'h55AA0000);

    send_frame(8'h3C, 1'b0, 16);
    UART_RX = 1'b0;
    model_frame(8'h3C, 1'b0);
    repeat (48) @(posedge HCLK);
    ahb_read(4'd1, d); check("ferr_hold_low", d, 32'h55AA0004);
    #1 UART_RX = 1'b1;
    idle(16);
    stat_w1c(32'h4);
    ahb_read(4'd1, d); check("ferr_clr", d, 32'h55AA0000);

    send_frame(8'h11, 1'b1, 16); idle(16); model_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1, 16); idle(16); model_frame(8'h22, 1'b1);
    ahb_read(4'd1, d); check("ovr_stat", d, 32'h55AA000A);
    ahb_read(4'd0, d); check("ovr_data", d, 32'h00000011);
    m_valid = 1'b0;
    stat_w1c(32'h8);
    ahb_read(4'd1, d); check("ovr_clr", d, 32'h55AA0000);

    send_frame(8'h66, 1'b1, 16); idle(16); model_frame(8'h66, 1'b1);
    fork
      send_frame(8'h77, 1'b1, 16);
      begin
        @(posedge HCLK);
        repeat (152) @(posedge HCLK);
        ahb_read(4'd0, d);
      end
    join
    check("coin_old", d, 32'h00000066);
    m_data = 8'h77;
    m_valid = 1'b1;
    idle(16);
    ahb_read(4'd1, d); check("coin_stat", d, 32'h55AA0002);
    ahb_read(4'd0, d); check("coin_data", d, 32'h00000077);
    m_valid = 1'b0;

    fork
      send_frame(8'hC3, 1'b1, 16);
      begin
        repeat (40) @(posedge HCLK);
        ahb_write(4'd2, 32'd24);
      end
    join
    model_frame(8'hC3, 1'b1);
    idle(16);
    data_chk("dvdr_mid_data");
    ahb_read(4'd2, d); check("dvdr_mid_rd", d, 32'd24);

    ahb_write(4'd2, 32'd0);
    ahb_read(4'd2, d); check("dvdr_zero_rd", d, 32'd0);
    send_frame(8'h81, 1'b1, 2); idle(10); model_frame(8'h81, 1'b1);
    data_chk("div_clamp_data");
    ahb_write(4'd2, 32'd16);

    send_frame(8'h99, 1'b1, 16); idle(16); model_frame(8'h99, 1'b1);
    send_frame(8'h42, 1'b0, 16); idle(16); model_frame(8'h42, 1'b0);
    ahb_read(4'd1, d); check("pre_rst_stat", d, 32'h55AA0006);
    fork
      send_frame(8'hF0, 1'b1, 16);
      begin
        @(posedge HCLK);
        repeat (87) @(posedge HCLK);
        #1 HRESET = 1'b1;
        @(posedge HCLK); #1 HRESET = 1'b0;
        check("rst_mid_irq", {31'b0, RX_IRQ}, 32'd0);
        ahb_read(4'd1, d); check("rst_mid_stat", d, 32'h55AA0000);
        ahb_read(4'd2, d); check("rst_mid_dvdr", d, 32'd434);
      end
    join
    m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    idle(20);
    stat_chk("rst_after_stat");
    data_chk("rst_after_data");
    send_frame(8'h5A, 1'b1, 434); idle(40); model_frame(8'h5A, 1'b1);
    stat_chk("5a_stat");
    data_chk("5a_data");

    for (int i = 0; i < 12; i++) begin
      div = $urandom_range(8, 40);
      b = 8'($urandom);
      ok = $urandom_range(0, 4) != 0;
      ahb_write(4'd2, div);
      ahb_read(4'd2, d); check("rnd_dvdr", d, div);
      send_frame(b, ok, div);
      idle(div);
      model_frame(b, ok);
      stat_chk("rnd_stat");
      check("rnd_irq", {31'b0, RX_IRQ}, {31'b0, m_valid});
      if ($urandom_range(0, 1) == 1) data_chk("rnd_data");
      if ($urandom_range(0, 2) == 0) begin
        stat_w1c(32'($urandom_range(0, 15)));
        stat_chk("rnd_w1c");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
